// File: rtl/detector_pkg.sv
// Shared types and constants for the vital-sign detector: age bands, band
// limits and the per-band normal ranges for blood pressure, breathing and heart rate.
package detector_pkg;

    localparam int unsigned DATA_W_DEF     = 10;
    localparam int unsigned CHILD_MAX_AGE  = 12;
    localparam int unsigned SENIOR_MIN_AGE = 60;

    typedef enum logic [1:0] {
        CHILD,
        ADULT,
        SENIOR
    } band_e;

    typedef struct packed {
        logic [15:0] bp_min;
        logic [15:0] bp_max;
        logic [15:0] br_min;
        logic [15:0] br_max;
        logic [15:0] hb_min;
        logic [15:0] hb_max;
    } limits_t;

    localparam limits_t CHILD_LIMITS  = '{bp_min: 16'd90, bp_max: 16'd110,
                                          br_min: 16'd18, br_max: 16'd30,
                                          hb_min: 16'd70, hb_max: 16'd120};
    localparam limits_t ADULT_LIMITS  = '{bp_min: 16'd90, bp_max: 16'd120,
                                          br_min: 16'd12, br_max: 16'd20,
                                          hb_min: 16'd60, hb_max: 16'd100};
    localparam limits_t SENIOR_LIMITS = '{bp_min: 16'd90, bp_max: 16'd140,
                                          br_min: 16'd12, br_max: 16'd25,
                                          hb_min: 16'd60, hb_max: 16'd110};

    function automatic limits_t band_limits(input band_e band);
        case (band)
            CHILD:   return CHILD_LIMITS;
            SENIOR:  return SENIOR_LIMITS;
            default: return ADULT_LIMITS;
        endcase
    endfunction

endpackage

// File: rtl/detector_range_check.sv
// Inclusive window comparator: flags a value that lies below min or above max.
module range_check #(
    parameter int unsigned W = 10
) (
    input  logic [W-1:0] value_i,
    input  logic [W-1:0] min_i,
    input  logic [W-1:0] max_i,
    output logic         out_of_range_o
);

    assign out_of_range_o = (value_i < min_i) || (value_i > max_i);

endmodule

// File: rtl/detector.sv
// Classifies three vital signs against age-dependent normal ranges and raises
// alarm when at least two are abnormal; all four outputs are registered.
module detector
    import detector_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] bloodP,
    input  logic [DATA_W-1:0] breathR,
    input  logic [DATA_W-1:0] heartB,
    input  logic [DATA_W-1:0] age,
    output logic              alarm,
    output logic              BP,
    output logic              BR,
    output logic              HB
);

    band_e   band;
    limits_t lim;

    logic [DATA_W-1:0] bp_min, bp_max, br_min, br_max, hb_min, hb_max;
    logic              bp_d, br_d, hb_d, alarm_d;
    logic              bp_q, br_q, hb_q, alarm_q;

    always_comb begin
        band = ADULT;
        if (age <= DATA_W'(CHILD_MAX_AGE)) begin
            band = CHILD;
        end else if (age >= DATA_W'(SENIOR_MIN_AGE)) begin
            band = SENIOR;
        end
    end

    assign lim    = band_limits(band);
    assign bp_min = DATA_W'(lim.bp_min);
    assign bp_max = DATA_W'(lim.bp_max);
    assign br_min = DATA_W'(lim.br_min);
    assign br_max = DATA_W'(lim.br_max);
    assign hb_min = DATA_W'(lim.hb_min);
    assign hb_max = DATA_W'(lim.hb_max);

    range_check #(.W(DATA_W)) u_bp_check (
        .value_i        (bloodP),
        .min_i          (bp_min),
        .max_i          (bp_max),
        .out_of_range_o (bp_d)
    );

    range_check #(.W(DATA_W)) u_br_check (
        .value_i        (breathR),
        .min_i          (br_min),
        .max_i          (br_max),
        .out_of_range_o (br_d)
    );

    range_check #(.W(DATA_W)) u_hb_check (
        .value_i        (heartB),
        .min_i          (hb_min),
        .max_i          (hb_max),
        .out_of_range_o (hb_d)
    );

    // 2-of-3 majority on the flags about to be registered, so alarm stays aligned with them
    assign alarm_d = (bp_d & br_d) | (bp_d & hb_d) | (br_d & hb_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bp_q    <= 1'b0;
            br_q    <= 1'b0;
            hb_q    <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            bp_q    <= bp_d;
            br_q    <= br_d;
            hb_q    <= hb_d;
            alarm_q <= alarm_d;
        end
    end

    assign BP    = bp_q;
    assign BR    = br_q;
    assign HB    = hb_q;
    assign alarm = alarm_q;

endmodule

// File: tb/tb_detector.sv
// Scoreboard bench for detector: a driver queues expected {alarm,BP,BR,HB}
// from a table-driven model; a monitor pops and compares after every edge.
module tb_detector;

    localparam int DATA_W = 10;

    // Normal ranges indexed by band: 0 = child, 1 = adult, 2 = senior
    localparam int BP_LO[3] = '{90, 90, 90};
    localparam int BP_HI[3] = '{110, 120, 140};
    localparam int BR_LO[3] = '{18, 12, 12};
    localparam int BR_HI[3] = '{30, 20, 25};
    localparam int HB_LO[3] = '{70, 60, 60};
    localparam int HB_HI[3] = '{120, 100, 110};

    localparam int EDGE_VALS[27] = '{0, 11, 12, 17, 18, 19, 20, 21, 25, 26, 30, 31,
                                     59, 60, 61, 69, 70, 89, 90, 100, 101, 110, 111,
                                     120, 121, 140, 141};

    typedef struct {
        int         id;
        int         age_v;
        int         bp_v;
        int         br_v;
        int         hb_v;
        logic [3:0] exp;
    } txn_t;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] bloodP, breathR, heartB, age;
    logic              alarm, BP, BR, HB;

    txn_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn_id = 0;

    detector #(.DATA_W(DATA_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bloodP  (bloodP),
        .breathR (breathR),
        .heartB  (heartB),
        .age     (age),
        .alarm   (alarm),
        .BP      (BP),
        .BR      (BR),
        .HB      (HB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] model(input int a, input int p, input int r, input int h);
        int  band;
        bit  fp, fr, fh;
        int  n;
        band = (a <= 12) ? 0 : ((a < 60) ? 1 : 2);
        fp = (p < BP_LO[band]) || (p > BP_HI[band]);
        fr = (r < BR_LO[band]) || (r > BR_HI[band]);
        fh = (h < HB_LO[band]) || (h > HB_HI[band]);
        n  = int'(fp) + int'(fr) + int'(fh);
        return {(n >= 2), fp, fr, fh};
    endfunction

    function automatic int rnd_vital();
        int sel;
        sel = int'($urandom_range(0, 3));
        if (sel < 2) return int'($urandom_range(0, 200));
        if (sel == 2) return EDGE_VALS[$urandom_range(0, 26)];
        return int'($urandom_range(0, 1023));
    endfunction

    function automatic int rnd_age();
        case ($urandom_range(0, 7))
            0:       return 0;
            1:       return 12;
            2:       return 13;
            3:       return 59;
            4:       return 60;
            5:       return 1023;
            default: return int'($urandom_range(0, 1023));
        endcase
    endfunction

    // Sets inputs and queues the response expected at the next rising edge
    task automatic apply(input int a, input int p, input int r, input int h);
        txn_t t;
        age     = DATA_W'(a);
        bloodP  = DATA_W'(p);
        breathR = DATA_W'(r);
        heartB  = DATA_W'(h);
        t.id    = txn_id;
        t.age_v = a;
        t.bp_v  = p;
        t.br_v  = r;
        t.hb_v  = h;
        t.exp   = model(a, p, r, h);
        txn_id++;
        exp_q.push_back(t);
    endtask

    task automatic drive(input int a, input int p, input int r, input int h);
        @(negedge clk);
        apply(a, p, r, h);
    endtask

    task automatic check_now(input string name, input logic [3:0] want);
        logic [3:0] got;
        got = {alarm, BP, BR, HB};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: {alarm,BP,BR,HB} got %b expected %b at %0t", name, got, want, $time);
        end else begin
            $display("%s: {alarm,BP,BR,HB}=%b ok", name, got);
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d responses still pending, expected 0", name, exp_q.size());
        end
    endtask

    // Monitor: one registered response is presented after every rising edge
    initial begin
        txn_t       t;
        logic [3:0] got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                t   = exp_q.pop_front();
                got = {alarm, BP, BR, HB};
                checks++;
                if (got !== t.exp) begin
                    errors++;
                    $display("FAIL txn%0d age=%0d bp=%0d br=%0d hb=%0d: {alarm,BP,BR,HB} got %b expected %b",
                             t.id, t.age_v, t.bp_v, t.br_v, t.hb_v, got, t.exp);
                end else begin
                    $display("txn%0d age=%0d bp=%0d br=%0d hb=%0d: {alarm,BP,BR,HB}=%b ok",
                             t.id, t.age_v, t.bp_v, t.br_v, t.hb_v, got);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b1;
        age     = '0;
        bloodP  = '0;
        breathR = '0;
        heartB  = '0;
        #1 rst_n = 1'b0;
        #2 check_now("reset_async_initial", 4'b0000);
        repeat (2) @(posedge clk);
        #1 check_now("reset_held_initial", 4'b0000);

        // Release between edges with all-zero vitals: first edge must flag everything
        @(negedge clk);
        rst_n = 1'b1;
        apply(30, 0, 0, 0);

        drive(30, 110, 16, 75);
        drive(30, 150, 16, 75);
        drive(30, 150, 16, 120);
        drive(30, 110, 16, 100);
        drive(30, 110, 16, 101);
        drive(30, 110, 16, 60);
        drive(30, 110, 16, 59);
        drive(12, 100, 20, 115);
        drive(13, 100, 20, 115);
        drive(60, 140, 25, 110);
        drive(59, 140, 25, 110);
        drive(1023, 141, 26, 111);
        drive(0, 90, 18, 70);
        drive(30, 0, 0, 0);
        drain("drain_directed");

        // Mid-run reset: outputs are all 1 here, drop rst_n between edges
        @(posedge clk);
        #2 check_now("pre_reset_outputs", 4'b1111);
        rst_n = 1'b0;
        #1 check_now("reset_async_midrun", 4'b0000);
        repeat (2) @(posedge clk);
        #1 check_now("reset_held_midrun", 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        apply(30, 150, 25, 120);

        for (int i = 0; i < 150; i++) begin
            drive(rnd_age(), rnd_vital(), rnd_vital(), rnd_vital());
        end
        drain("drain_random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/detector.md
DETECTOR -- requirements
Module: detector

Interface
REQ-001 Parameter DATA_W, default 10, width of every vital-sign and age input.
REQ-002 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port bloodP  input  DATA_W  systolic blood pressure, unsigned, mmHg.
REQ-005 Port breathR  input  DATA_W  breathing rate, unsigned, breaths/min.
REQ-006 Port heartB  input  DATA_W  heart rate, unsigned, beats/min.
REQ-007 Port age  input  DATA_W  subject age, unsigned, years.
REQ-008 Port alarm  output  1  registered; 1 = two or more vitals abnormal (lie indication).
REQ-009 Port BP  output  1  registered; 1 = bloodP outside the normal range for the age band.
REQ-010 Port BR  output  1  registered; 1 = breathR outside the normal range for the age band.
REQ-011 Port HB  output  1  registered; 1 = heartB outside the normal range for the age band.
REQ-012 The design SHALL have one clock and an asynchronous active-low reset (clk, rst_n); no other timing inputs.

Function
REQ-013 Inputs SHALL be treated as unsigned; no input is registered before classification, so each rising edge evaluates the values present at that edge.
REQ-014 The age band SHALL be: CHILD for age 0..12, ADULT for age 13..59, SENIOR for age >= 60, including all values up to 2^DATA_W-1.
REQ-015 Normal ranges (inclusive) SHALL be: CHILD BP 90..110, BR 18..30, HB 70..120; ADULT BP 90..120, BR 12..20, HB 60..100; SENIOR BP 90..140, BR 12..25, HB 60..110.
REQ-016 Each flag SHALL be 1 when value < min or value > max; min and max themselves are normal.
REQ-017 A value of 0 SHALL be abnormal in every band.
REQ-018 alarm SHALL be 1 exactly when at least two of the three next-state flags are 1 (2-of-3 majority).
REQ-019 BP, BR, HB and alarm SHALL update together on the same rising edge; latency is one cycle from sampled inputs to outputs, with no combinational path from any input to any output.
REQ-020 Outputs SHALL hold their value between edges; input changes between edges have no effect until the next edge.
REQ-021 A change of age alone SHALL re-evaluate all three flags against the new band on the next edge.
REQ-022 There SHALL be no sticky or latched state; outputs follow the most recent sample every cycle.

Reset
REQ-023 While rst_n = 0, alarm, BP, BR and HB SHALL be 0, asserted asynchronously without waiting for clk.
REQ-024 On the first rising edge after rst_n returns to 1, outputs SHALL reflect the inputs sampled at that edge.
REQ-025 Reset asserted mid-operation SHALL clear all outputs immediately, regardless of prior values.

Structure
REQ-026 A package detector_pkg SHALL hold:
- the age-band enum (CHILD, ADULT, SENIOR);
- the band age limits (12, 60);
- the nine min/max threshold pairs;
- DATA_W default.
REQ-027 One sub-module, range_check (value, min, max -> out_of_range), SHALL be instantiated three times, once each for BP, BR and HB.
REQ-028 Band selection and threshold muxing SHALL be combinational in detector; only the four outputs are flops.

Verification
REQ-029 Zero inputs: rst_n released; age=30, bloodP=breathR=heartB=0 -> after one edge BP=BR=HB=1, alarm=1.
REQ-030 Normal adult: age=30, bloodP=110, breathR=16, heartB=75 -> BP=BR=HB=0, alarm=0.
REQ-031 Single abnormal: age=30, bloodP=150, breathR=16, heartB=75 -> BP=1, alarm=0. Adding heartB=120 -> BP=1, HB=1, alarm=1 on the next edge.
REQ-032 Heart-rate boundaries, adult, other vitals normal:
- heartB=100 -> HB=0; 101 -> HB=1;
- heartB=60 -> HB=0; 59 -> HB=1.
REQ-033 Band switch: age=12, heartB=115, bloodP=100, breathR=20 -> all 0. Changing age to 13 -> HB=1 and BP=0 on the next edge (BR stays 0).
REQ-034 Reset mid-run: outputs at 1 then rst_n=0 between edges -> all outputs 0 immediately and held 0 while low.
